// File: rtl/miss_arbiter_pkg.sv
// Shared constants for the cache miss arbiter: state encoding, block geometry
// and the memory read latency that benches use to model the memory pipeline.
package miss_arbiter_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    // Words per cache block; each word is 16 bits, so a block spans 16 bytes.
    localparam int BLOCK_WORDS = 8;

    // Cycles between issuing a read and its data returning with mem_data_valid.
    localparam int MEM_LATENCY = 4;

endpackage

// File: rtl/fill_counter.sv
// 4-bit word counter used for both the issue and the receive side of a fill.
// Clear has priority over increment.
module fill_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] cnt
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Next count: clear on a new fill, otherwise step when asked.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 4'd0;
        end else if (inc) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/miss_arbiter.sv
// Arbitrates the I-cache miss, D-cache miss and write-through store ports onto
// one pipelined memory port. Stores are served combinationally in IDLE; a miss
// moves to FILL, issues 8 word reads back to back and steers the returning
// words into the owning cache's data array.
module miss_arbiter
    import miss_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        icache_miss,
    input  logic [15:0] icache_miss_addr,
    input  logic        dcache_miss,
    input  logic [15:0] dcache_miss_addr,
    input  logic        dcache_wr,
    input  logic [15:0] dcache_wr_addr,
    input  logic [15:0] dcache_wr_data,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_to_mem,
    input  logic [15:0] mem_data_from_mem,
    input  logic        mem_data_valid,
    output logic [15:0] fill_data,
    output logic [2:0]  fill_word,
    output logic        fill_we_i,
    output logic        fill_we_d,
    output logic        icache_fill_done,
    output logic        dcache_fill_done,
    output logic        wr_ack
);

    localparam logic [3:0] BLOCK_WORDS_C = 4'(BLOCK_WORDS);
    localparam logic [3:0] LAST_WORD_C   = 4'(BLOCK_WORDS - 1);

    logic [0:0]  state_q, state_d;
    logic        owner_q, owner_d;
    logic [11:0] base_q, base_d;

    logic [3:0]  issue_cnt;
    logic [3:0]  recv_cnt;
    logic        cnt_clr;
    logic        issue_inc;
    logic        recv_inc;

    fill_counter u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (issue_inc),
        .cnt   (issue_cnt)
    );

    fill_counter u_recv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (recv_inc),
        .cnt   (recv_cnt)
    );

    // Arbitration, read issue, fill steering and next-state decode.
    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        base_d           = base_q;
        cnt_clr          = 1'b0;
        issue_inc        = 1'b0;
        recv_inc         = 1'b0;
        mem_enable       = 1'b0;
        mem_wr           = 1'b0;
        mem_addr         = 16'h0000;
        mem_data_to_mem  = 16'h0000;
        fill_data        = 16'h0000;
        fill_word        = 3'd0;
        fill_we_i        = 1'b0;
        fill_we_d        = 1'b0;
        icache_fill_done = 1'b0;
        dcache_fill_done = 1'b0;
        wr_ack           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A store takes the port this cycle and blocks any miss capture.
                if (dcache_wr) begin
                    mem_enable      = 1'b1;
                    mem_wr          = 1'b1;
                    mem_addr        = dcache_wr_addr;
                    mem_data_to_mem = dcache_wr_data;
                    wr_ack          = 1'b1;
                end else if (dcache_miss) begin
                    state_d = ST_FILL;
                    owner_d = OWNER_D;
                    base_d  = dcache_miss_addr[15:4];
                    cnt_clr = 1'b1;
                end else if (icache_miss) begin
                    state_d = ST_FILL;
                    owner_d = OWNER_I;
                    base_d  = icache_miss_addr[15:4];
                    cnt_clr = 1'b1;
                end
            end

            ST_FILL: begin
                if (issue_cnt < BLOCK_WORDS_C) begin
                    mem_enable = 1'b1;
                    mem_addr   = {base_q, issue_cnt[2:0], 1'b0};
                    issue_inc  = 1'b1;
                end
                // Returned words beyond the block size are dropped.
                if (mem_data_valid && (recv_cnt < BLOCK_WORDS_C)) begin
                    fill_data = mem_data_from_mem;
                    fill_word = recv_cnt[2:0];
                    fill_we_i = ~owner_q;
                    fill_we_d = owner_q;
                    recv_inc  = 1'b1;
                    if (recv_cnt == LAST_WORD_C) begin
                        icache_fill_done = ~owner_q;
                        dcache_fill_done = owner_q;
                        state_d          = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, owner and captured block base.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= OWNER_I;
            base_q  <= 12'h000;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            base_q  <= base_d;
        end
    end

endmodule

// File: tb/tb_miss_arbiter.sv
// Directed bench for miss_arbiter: an IDLE vector table followed by fill,
// priority, store-during-fill and reset-mid-fill sequences against a
// 4-cycle pipelined memory model.
module tb_miss_arbiter;
    import miss_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        icache_miss = 1'b0;
    logic [15:0] icache_miss_addr = 16'h0;
    logic        dcache_miss = 1'b0;
    logic [15:0] dcache_miss_addr = 16'h0;
    logic        dcache_wr = 1'b0;
    logic [15:0] dcache_wr_addr = 16'h0;
    logic [15:0] dcache_wr_data = 16'h0;
    logic        mem_enable, mem_wr;
    logic [15:0] mem_addr, mem_data_to_mem;
    logic [15:0] mem_data_from_mem;
    logic        mem_data_valid;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        fill_we_i, fill_we_d;
    logic        icache_fill_done, dcache_fill_done, wr_ack;

    logic        extra_valid = 1'b0;
    logic [15:0] extra_data = 16'h0;

    int n_tests = 0;
    int n_fail = 0;

    localparam logic [57:0] ZERO = '0;

    miss_arbiter dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .icache_miss       (icache_miss),
        .icache_miss_addr  (icache_miss_addr),
        .dcache_miss       (dcache_miss),
        .dcache_miss_addr  (dcache_miss_addr),
        .dcache_wr         (dcache_wr),
        .dcache_wr_addr    (dcache_wr_addr),
        .dcache_wr_data    (dcache_wr_data),
        .mem_enable        (mem_enable),
        .mem_wr            (mem_wr),
        .mem_addr          (mem_addr),
        .mem_data_to_mem   (mem_data_to_mem),
        .mem_data_from_mem (mem_data_from_mem),
        .mem_data_valid    (mem_data_valid),
        .fill_data         (fill_data),
        .fill_word         (fill_word),
        .fill_we_i         (fill_we_i),
        .fill_we_d         (fill_we_d),
        .icache_fill_done  (icache_fill_done),
        .dcache_fill_done  (dcache_fill_done),
        .wr_ack            (wr_ack)
    );

    // Clock.
    always #5 clk = ~clk;

    // Memory contents: each word is a fixed function of its address.
    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    // Pipelined read model, independent of DUT reset: a read issued in one
    // cycle returns MEM_LATENCY cycles later.
    logic [3:0]  pipe_v = 4'b0;
    logic [15:0] pipe_a0 = 16'h0, pipe_a1 = 16'h0, pipe_a2 = 16'h0, pipe_a3 = 16'h0;

    always @(posedge clk) begin
        pipe_v  <= {pipe_v[2:0], mem_enable & ~mem_wr};
        pipe_a0 <= mem_addr;
        pipe_a1 <= pipe_a0;
        pipe_a2 <= pipe_a1;
        pipe_a3 <= pipe_a2;
    end

    assign mem_data_valid    = pipe_v[MEM_LATENCY-1] | extra_valid;
    assign mem_data_from_mem = pipe_v[MEM_LATENCY-1] ? mem_fn(pipe_a3) : extra_data;

    // Output bundle layout used by every comparison.
    function automatic logic [57:0] pk(
        input logic en, input logic wr, input logic [15:0] addr, input logic [15:0] dto,
        input logic [15:0] fd, input logic [2:0] fw, input logic wei, input logic wed,
        input logic di, input logic dd, input logic ack);
        return {en, wr, addr, dto, fd, fw, wei, wed, di, dd, ack};
    endfunction

    task automatic check(input string name, input logic [57:0] exp);
        logic [57:0] act;
        act = pk(mem_enable, mem_wr, mem_addr, mem_data_to_mem, fill_data, fill_word,
                 fill_we_i, fill_we_d, icache_fill_done, dcache_fill_done, wr_ack);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Step to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        icache_miss = 1'b0; icache_miss_addr = 16'h0;
        dcache_miss = 1'b0; dcache_miss_addr = 16'h0;
        dcache_wr = 1'b0; dcache_wr_addr = 16'h0; dcache_wr_data = 16'h0;
        extra_valid = 1'b0; extra_data = 16'h0;
    endtask

    // Walk FILL cycles 1..ncyc checking each against the nominal timeline:
    // reads in cycles 1-8, words back in cycles 5-12, done in cycle 12.
    // A store is raised in cycle wr_cyc (0 = none) and must not be acked.
    task automatic run_fill(input logic own, input logic [11:0] base, input int ncyc, input int wr_cyc);
        logic        en, v;
        logic [2:0]  w;
        logic [15:0] addr, d;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            if (c == wr_cyc) begin
                dcache_wr = 1'b1; dcache_wr_addr = 16'h1111; dcache_wr_data = 16'h2222;
            end
            @(negedge clk);
            en   = (c <= 8);
            addr = en ? {base, 3'(c - 1), 1'b0} : 16'h0;
            v    = (c >= 5) && (c <= 12);
            w    = v ? 3'(c - 5) : 3'd0;
            d    = v ? mem_fn({base, w, 1'b0}) : 16'h0;
            check($sformatf("fill_%s_%03h_c%0d", own ? "d" : "i", base, c),
                  pk(en, 1'b0, addr, 16'h0, d, w, v & ~own, v & own,
                     (c == 12) & ~own, (c == 12) & own, 1'b0));
        end
    endtask

    typedef struct {
        logic        wr, im, dm;
        logic [15:0] waddr, wdata;
        logic        xv;
        logic [15:0] xd;
        logic [57:0] exp;
    } vec_t;

    vec_t vt[8];

    initial begin
        // IDLE vectors: stores, stores masking misses, stray memory data.
        vt[0] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, ZERO};
        vt[1] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1234, ZERO};
        vt[2] = '{1'b1, 1'b0, 1'b0, 16'h2002, 16'hBEEF, 1'b0, 16'h0000,
                  pk(1, 1, 16'h2002, 16'hBEEF, 16'h0, 3'd0, 0, 0, 0, 0, 1)};
        vt[3] = '{1'b1, 1'b1, 1'b1, 16'h0FFE, 16'h0001, 1'b0, 16'h0000,
                  pk(1, 1, 16'h0FFE, 16'h0001, 16'h0, 3'd0, 0, 0, 0, 0, 1)};
        vt[4] = '{1'b1, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hAAAA,
                  pk(1, 1, 16'hFFFF, 16'hFFFF, 16'h0, 3'd0, 0, 0, 0, 0, 1)};
        vt[5] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, ZERO};
        vt[6] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000,
                  pk(1, 1, 16'h0000, 16'h0000, 16'h0, 3'd0, 0, 0, 0, 0, 1)};
        vt[7] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, ZERO};

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_held", ZERO);
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("after_reset", ZERO);

        // Vector table.
        for (int i = 0; i < 8; i++) begin
            tick();
            dcache_wr = vt[i].wr; dcache_wr_addr = vt[i].waddr; dcache_wr_data = vt[i].wdata;
            icache_miss = vt[i].im; icache_miss_addr = 16'h4444;
            dcache_miss = vt[i].dm; dcache_miss_addr = 16'h5555;
            extra_valid = vt[i].xv; extra_data = vt[i].xd;
            @(negedge clk);
            check($sformatf("vec%0d", i), vt[i].exp);
        end
        tick();
        clear_inputs();
        @(negedge clk);
        check("idle_quiet", ZERO);

        // I-miss at 0x1236.
        tick();
        icache_miss = 1'b1; icache_miss_addr = 16'h1236;
        @(negedge clk);
        check("i_capture", ZERO);
        run_fill(1'b0, 12'h123, 12, 0);
        tick();
        icache_miss = 1'b0;
        @(negedge clk);
        check("i_back_idle", ZERO);

        // Simultaneous misses: D first, then I without a gap.
        tick();
        icache_miss = 1'b1; icache_miss_addr = 16'h0040;
        dcache_miss = 1'b1; dcache_miss_addr = 16'h8008;
        @(negedge clk);
        check("both_capture", ZERO);
        run_fill(1'b1, 12'h800, 12, 0);
        tick();
        dcache_miss = 1'b0;
        @(negedge clk);
        check("rearb_idle", ZERO);
        run_fill(1'b0, 12'h004, 12, 0);
        tick();
        icache_miss = 1'b0;
        @(negedge clk);
        check("both_done_idle", ZERO);

        // Store with a D-miss in IDLE: store first, fill next.
        tick();
        dcache_wr = 1'b1; dcache_wr_addr = 16'h2002; dcache_wr_data = 16'hBEEF;
        dcache_miss = 1'b1; dcache_miss_addr = 16'h3456;
        @(negedge clk);
        check("store_over_miss", pk(1, 1, 16'h2002, 16'hBEEF, 16'h0, 3'd0, 0, 0, 0, 0, 1));
        tick();
        dcache_wr = 1'b0;
        @(negedge clk);
        check("miss_after_store", ZERO);
        run_fill(1'b1, 12'h345, 12, 0);
        tick();
        dcache_miss = 1'b0;
        @(negedge clk);
        check("store_miss_idle", ZERO);

        // Store raised in FILL cycle 3 waits for IDLE.
        tick();
        icache_miss = 1'b1; icache_miss_addr = 16'h7FF0;
        @(negedge clk);
        check("i2_capture", ZERO);
        run_fill(1'b0, 12'h7FF, 12, 3);
        tick();
        icache_miss = 1'b0;
        @(negedge clk);
        check("deferred_store", pk(1, 1, 16'h1111, 16'h2222, 16'h0, 3'd0, 0, 0, 0, 0, 1));
        tick();
        dcache_wr = 1'b0;
        @(negedge clk);
        check("deferred_done", ZERO);

        // Reset after 5 returned words; the last 3 words must be ignored.
        tick();
        dcache_miss = 1'b1; dcache_miss_addr = 16'hA5A0;
        @(negedge clk);
        check("d3_capture", ZERO);
        run_fill(1'b1, 12'hA5A, 9, 0);
        tick();
        rst_n = 1'b0;
        dcache_miss = 1'b0;
        #1;
        check("rst_async", ZERO);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 11; c <= 13; c++) begin
            tick();
            @(negedge clk);
            check($sformatf("rst_drop_c%0d", c), ZERO);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Runaway guard.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/miss_arbiter.md
MISS_ARBITER -- requirements
Module: miss_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-002 icache_miss  input  1  I-cache miss request, level, held until icache_fill_done; icache_miss_addr  input  16  byte address of the missing instruction.
REQ-003 dcache_miss  input  1  D-cache miss request, level, held until dcache_fill_done; dcache_miss_addr  input  16  byte address of the missing data.
REQ-004 dcache_wr  input  1  write-through store request, level, held until wr_ack; dcache_wr_addr  input  16  store address; dcache_wr_data  input  16  store data.
REQ-005 mem_enable  output  1; mem_wr  output  1; mem_addr  output  16; mem_data_to_mem  output  16; mem_data_from_mem  input  16; mem_data_valid  input  1 (shared pipelined memory: one access per cycle, read data returns 4 cycles later with mem_data_valid).
REQ-006 fill_data  output  16  returned word; fill_word  output  3  word index in block; fill_we_i  output  1; fill_we_d  output  1  write strobe to I/D cache data array.
REQ-007 icache_fill_done  output  1; dcache_fill_done  output  1  one-cycle pulse, block complete; wr_ack  output  1  one-cycle pulse, store issued.

Function
REQ-008 FSM SHALL have two states: IDLE and FILL; registered owner bit (0 = I, 1 = D); 4-bit issue_cnt and recv_cnt.
REQ-009 In IDLE, priority SHALL be dcache_wr > dcache_miss > icache_miss; only the highest-priority pending request is served that cycle.
REQ-010 Store in IDLE: mem_enable=1, mem_wr=1, mem_addr=dcache_wr_addr, mem_data_to_mem=dcache_wr_data, wr_ack=1, all in the same cycle (combinational); state remains IDLE.
REQ-011 Miss in IDLE (no store pending): on the next edge, capture block base = addr[15:4], set owner, clear both counters, enter FILL.
REQ-012 In FILL while issue_cnt<8: mem_enable=1, mem_wr=0, mem_addr={base,issue_cnt[2:0],1'b0}; issue_cnt increments each cycle; the 8 addresses go out in 8 consecutive cycles.
REQ-013 In FILL, each cycle mem_data_valid=1: fill_data=mem_data_from_mem, fill_word=recv_cnt[2:0], fill_we_i=~owner or fill_we_d=owner (combinational); recv_cnt increments.
REQ-014 The cycle the 8th word is received SHALL pulse the owner's fill_done alongside the last write strobe; next state = IDLE.
REQ-015 Nominal miss latency: 8 issue cycles + 4 memory latency; done in the 12th FILL cycle; 13 cycles from IDLE capture edge to return to IDLE.
REQ-016 Requests arriving during FILL (including stores) SHALL wait; wr_ack and fill strobes for a non-owner SHALL stay 0.
REQ-017 mem_data_valid in IDLE, or after recv_cnt reaches 8, SHALL be ignored (no strobes, no counter change).
REQ-018 Requesters deassert miss in the cycle after done; the arbiter SHALL re-arbitrate in IDLE that cycle, so a pending other requester starts without an idle gap.
REQ-019 When not driven as above: mem_enable, mem_wr, fill_we_*, *_done, wr_ack = 0; mem_addr, mem_data_to_mem, fill_data = 0; fill_word = 0.

Reset
REQ-020 rst_n low SHALL asynchronously force IDLE, owner=0, counters=0, captured base=0; all outputs at REQ-019 values.
REQ-021 Reset mid-FILL SHALL abandon the fill without a done pulse; memory data still in flight SHALL be ignored per REQ-017.

Structure
REQ-022 Shared package miss_arbiter_pkg SHALL hold the state encoding (IDLE=0, FILL=1), BLOCK_WORDS=8, and MEM_LATENCY=4 (the latter for benches only).
REQ-023 One sub-module fill_counter (4-bit, clear, increment-enable, async active-low reset) SHALL be instantiated twice, for issue_cnt and recv_cnt.

Verification
REQ-024 icache_miss=1, addr 0x1236 -> mem_addr 0x1230,0x1232..0x123E in 8 consecutive cycles; 8 fill_we_i strobes, fill_word 0..7; icache_fill_done 12 cycles after FILL entry.
REQ-025 icache_miss and dcache_miss rise together (0x0040, 0x8008) -> D block 0x8000-0x800E fills first; I fill starts the cycle after dcache_fill_done.
REQ-026 dcache_wr (0x2002, 0xBEEF) and dcache_miss together in IDLE -> mem_wr=1 with addr 0x2002/data 0xBEEF and wr_ack that cycle; fill starts next cycle.
REQ-027 dcache_wr raised in the 3rd FILL cycle -> wr_ack stays 0 until IDLE, then the store issues in the first IDLE cycle.
REQ-028 rst_n pulsed low after 5 returned words -> outputs 0 immediately; remaining 3 mem_data_valid pulses produce no strobes and no done.
REQ-029 mem_data_valid toggled in IDLE with no request -> no fill_we_* and no done.
